// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor: FSM state encoding and counter sizing.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Counter must hold values 0..width, hence clog2(width+1).
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor_cell.sv
// One-bit full subtractor built from two half-subtractor stages whose borrows are ORed.
module full_subtractor_cell (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic d1;
    logic b1;
    logic b2;

    // First stage: x - y; second stage: (x - y) - bin.
    always_comb begin
        d1   = x ^ y;
        b1   = ~x & y;
        d    = d1 ^ bin;
        b2   = ~d1 & bin;
        bout = b1 | b2;
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor with valid/ready handshake, LSB first, one bit per cycle.
// Optional macro SERIAL_SUBTRACTOR_OVERFLOW_EN adds a two's-complement overflow output.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    output logic             overflow,
`endif
    output logic             busy
);

    localparam int unsigned CntW = cnt_width(WIDTH);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_sh_q, b_sh_q, diff_q;
    logic              borrow_q;
    logic [CntW-1:0]   cnt_q;
    logic              accept;
    logic              last_bit;
    logic              d_bit;
    logic              bout_bit;

    assign accept   = in_valid & in_ready;
    assign last_bit = (cnt_q == CntW'(WIDTH - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_valid)  state_d = StRun;
            StRun:   if (last_bit)  state_d = StDone;
            StDone:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        busy      = (state_q == StRun) || (state_q == StDone);
    end

    full_subtractor_cell u_cell (
        .x    (a_sh_q[0]),
        .y    (b_sh_q[0]),
        .bin  (borrow_q),
        .d    (d_bit),
        .bout (bout_bit)
    );

    // Operands shift right; result bits enter at the MSB so diff is aligned after WIDTH steps.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
        end else if (accept) begin
            a_sh_q   <= a;
            b_sh_q   <= b;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
        end else if (state_q == StRun) begin
            a_sh_q   <= a_sh_q >> 1;
            b_sh_q   <= b_sh_q >> 1;
            diff_q   <= {d_bit, diff_q[WIDTH-1:1]};
            borrow_q <= bout_bit;
            cnt_q    <= cnt_q + CntW'(1);
        end
    end

    assign diff       = diff_q;
    assign borrow_out = borrow_q;

`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    // Operand MSBs are shifted out during RUN, so keep them for the overflow test.
    logic a_msb_q, b_msb_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
        end else if (accept) begin
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= b[WIDTH-1];
        end
    end

    assign overflow = (a_msb_q ^ b_msb_q) & (diff_q[WIDTH-1] ^ a_msb_q);
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8): directed vectors plus random operands with backpressure.
module tb_serial_subtractor;

    localparam int unsigned W = 8;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         busy;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    logic         overflow;
`endif

    int total = 0;
    int bad   = 0;

    // {overflow, borrow, diff}
    logic [W+1:0] exp_q[$];

    serial_subtractor #(.WIDTH(W)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff       (diff),
        .borrow_out (borrow_out),
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
        .overflow   (overflow),
`endif
        .busy       (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a transfer happens on the next edge when out_valid and out_ready are both high.
    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got diff 0x%0h with empty scoreboard", diff);
            end else begin
                logic [W+1:0] e;
                e = exp_q.pop_front();
                check("diff", 32'(diff), 32'(e[W-1:0]));
                check("borrow_out", 32'(borrow_out), 32'(e[W]));
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
                check("overflow", 32'(overflow), 32'(e[W+1]));
`endif
            end
        end
    end

    // Issue one operation and return the edge count from the accept edge (counted as the first)
    // up to the edge after which out_valid is seen.
    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_, output int lat);
        int guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clock); #1;
            guard++;
        end
        check("in_ready_before_issue", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a        = ta;
        b        = tb_;
        @(posedge clock); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 50) begin
            @(posedge clock); #1;
            lat++;
        end
        if (!out_valid) check("out_valid_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic drain(input bit rand_bp);
        bit xfer = 1'b0;
        int guard = 0;
        while (!xfer && guard < 100) begin
            out_ready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
            xfer = out_valid && out_ready;
            @(posedge clock); #1;
            guard++;
        end
        out_ready = 1'b0;
        if (!xfer) check("drain_timeout", 32'(xfer), 32'd1);
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic [W-1:0] ed, input logic eb, input logic eo,
                          input bit rand_bp);
        int lat;
        exp_q.push_back({eo, eb, ed});
        issue(ta, tb_, lat);
        drain(rand_bp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_diff"}, 32'(diff), 32'd0);
        check({tag, "_borrow_out"}, 32'(borrow_out), 32'd0);
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
        check({tag, "_overflow"}, 32'(overflow), 32'd0);
`endif
    endtask

    initial begin
        int lat;
        logic [W-1:0] ra, rb, rd;
        logic         rbo, rov;

        repeat (3) @(posedge clock);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;
        @(posedge clock); #1;

        // 5 - 3 with latency check: out_valid WIDTH+1 edges after accept.
        exp_q.push_back({1'b0, 1'b0, 8'h02});
        issue(8'h05, 8'h03, lat);
        check("latency", 32'(lat), 32'(W + 1));
        check("busy_in_done", 32'(busy), 32'd1);
        drain(1'b0);

        run_op(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b0);
        run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0);
        run_op(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

        // Hold in DONE for 5 cycles while offering new operands that must be ignored.
        exp_q.push_back({1'b0, 1'b0, 8'h10});
        issue(8'h20, 8'h10, lat);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            a        = 8'hAA;
            b        = 8'h55;
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_diff", 32'(diff), 32'h10);
            check("hold_borrow", 32'(borrow_out), 32'd0);
            @(posedge clock); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        check("idle_after_done_in_ready", 32'(in_ready), 32'd1);
        check("idle_after_done_out_valid", 32'(out_valid), 32'd0);
        check("idle_hold_diff", 32'(diff), 32'h10);
        repeat (2) @(posedge clock);
        #1;
        check("idle_stays_idle", 32'(in_ready), 32'd1);

        // Asynchronous reset three cycles into RUN: no result may be produced.
        in_valid = 1'b1;
        a        = 8'hFF;
        b        = 8'h01;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("midrun_reset");
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        run_op(8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 256; i++) begin
            ra  = W'($urandom);
            rb  = W'($urandom);
            rd  = ra - rb;
            rbo = (ra < rb);
            rov = (ra[W-1] != rb[W-1]) && (rd[W-1] != ra[W-1]);
            run_op(ra, rb, rd, rbo, rov, 1'b1);
        end

        repeat (3) @(posedge clock);
        #1;
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
